// File: rtl/lsu_sequencer_if.sv
// Load/store sequencer bus bundle: CPU request/response channel plus the memory data port.
// Handshake: a request transfers on a posedge where req_valid && req_ready; resp_valid is a
// single-cycle pulse with no backpressure, and the memory side has no handshake at all.
interface lsu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_addrsrc;
  logic [31:0] mem_rd;

  // master is the environment (CPU datapath plus memory); slave is the sequencer
  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, busy,
    input  mem_we, mem_op, mem_addr, mem_wd, mem_addrsrc
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, busy,
    output mem_we, mem_op, mem_addr, mem_wd, mem_addrsrc
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: aligned accesses go out natively, misaligned ones become two word
// accesses (plus read-modify-write for stores); one response pulse per accepted request.
module lsu_sequencer (
  input  logic             clk,
  input  logic             reset_n,
  lsu_sequencer_if.slave   bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic        r_we, r_mis;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, w0, w1;
  logic        req_half, req_byte, req_mis, r_half;
  logic [2:0]  req_op_n;
  logic [5:0]  sh;
  logic [63:0] st_data, st_mask, merged;
  logic [31:0] ld_word, ld_result;
  logic [31:0] word0_addr, word1_addr;
  logic        we_raw, ready;
  logic [2:0]  op_o;
  logic [31:0] addr_o, wd_o;
  logic        addrsrc_o;

  assign req_half = (bus.req_op == 3'b010) || (bus.req_op == 3'b101);
  assign req_byte = (bus.req_op == 3'b001) || (bus.req_op == 3'b100);
  // Unlisted op codes are folded to word at accept time so later logic sees only legal codes.
  assign req_op_n = (req_half || req_byte) ? bus.req_op : 3'b011;
  assign req_mis  = req_byte ? 1'b0
                  : req_half ? (bus.req_addr[1:0] == 2'b11)
                  : (bus.req_addr[1:0] != 2'b00);

  assign r_half     = (r_op == 3'b010) || (r_op == 3'b101);
  assign sh         = {r_addr[1:0], 3'b000};
  assign word0_addr = {r_addr[31:2], 2'b00};
  assign word1_addr = {r_addr[31:2] + 30'd1, 2'b00};

  // {w1,w0} is the 8-byte window holding the misaligned datum at byte offset r_addr[1:0].
  assign st_data = {32'd0, r_wdata} << sh;
  assign st_mask = (r_half ? 64'h0000_0000_0000_ffff : 64'h0000_0000_ffff_ffff) << sh;
  assign merged  = ({w1, w0} & ~st_mask) | (st_data & st_mask);
  assign ld_word = 32'({w1, w0} >> sh);

  always_comb begin
    ld_result = ld_word;
    if (!r_mis)                ld_result = w0;
    else if (r_op == 3'b010)   ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
    else if (r_op == 3'b101)   ld_result = {16'd0, ld_word[15:0]};
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    we_raw    = 1'b0;
    op_o      = 3'b000;
    addr_o    = 32'd0;
    wd_o      = 32'd0;
    addrsrc_o = 1'b1;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        addrsrc_o = 1'b0;
        if (bus.req_valid) state_nx = req_mis ? RD0 : ACC;
      end
      ACC: begin
        op_o     = r_op;
        addr_o   = r_addr;
        wd_o     = r_wdata;
        we_raw   = r_we;
        state_nx = RESP;
      end
      RD0: begin
        op_o     = 3'b011;
        addr_o   = word0_addr;
        state_nx = RD1;
      end
      RD1: begin
        op_o     = 3'b011;
        addr_o   = word1_addr;
        state_nx = r_we ? WR0 : RESP;
      end
      WR0: begin
        op_o     = 3'b011;
        addr_o   = word0_addr;
        wd_o     = merged[31:0];
        we_raw   = 1'b1;
        state_nx = WR1;
      end
      WR1: begin
        op_o     = 3'b011;
        addr_o   = word1_addr;
        wd_o     = merged[63:32];
        we_raw   = 1'b1;
        state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      r_we           <= 1'b0;
      r_mis          <= 1'b0;
      r_op           <= 3'b000;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      w0             <= 32'd0;
      w1             <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      state          <= state_nx;
      bus.resp_valid <= (state == RESP);
      if (state == IDLE && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_mis   <= req_mis;
        r_op    <= req_op_n;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if ((state == ACC && !r_we) || state == RD0) w0 <= bus.mem_rd;
      if (state == RD1)                            w1 <= bus.mem_rd;
      if (state == RESP) bus.resp_rdata <= r_we ? 32'd0 : ld_result;
    end
  end

  // Gating with reset_n keeps a write from committing on the reset edge itself.
  assign bus.mem_we      = we_raw & reset_n;
  assign bus.mem_op      = op_o;
  assign bus.mem_addr    = addr_o;
  assign bus.mem_wd      = wd_o;
  assign bus.mem_addrsrc = addrsrc_o;
  assign bus.req_ready   = ready;
  assign bus.busy        = ~ready;
  assign dbg_state       = state;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: byte-array memory model, byte-level reference model, directed
// scenarios followed by randomized requests.
module tb_lsu_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;
  logic       preload_req = 1'b0;

  lsu_sequencer_if bif ();

  lsu_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- memory model (device side) ----------------
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  rb0, rb1, rb2, rb3;

  function automatic logic [7:0] init_byte(int i);
    logic [63:0] pre;
    pre = 64'h88776655_44332211;
    if (i >= 16 && i < 24) return pre[8*(i-16) +: 8];
    return 8'(i * 37 + 5);
  endfunction

  assign rb0 = mem[bif.mem_addr[7:0]];
  assign rb1 = mem[8'(bif.mem_addr[7:0] + 8'd1)];
  assign rb2 = mem[8'(bif.mem_addr[7:0] + 8'd2)];
  assign rb3 = mem[8'(bif.mem_addr[7:0] + 8'd3)];

  always_comb begin
    bif.mem_rd = {rb3, rb2, rb1, rb0};
    case (bif.mem_op)
      3'b001:  bif.mem_rd = {{24{rb0[7]}}, rb0};
      3'b100:  bif.mem_rd = {24'd0, rb0};
      3'b010:  bif.mem_rd = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  bif.mem_rd = {16'd0, rb1, rb0};
      default: bif.mem_rd = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (bif.mem_we) begin
      int n;
      n = (bif.mem_op == 3'b001 || bif.mem_op == 3'b100) ? 1
        : (bif.mem_op == 3'b010 || bif.mem_op == 3'b101) ? 2 : 4;
      for (int i = 0; i < n; i++)
        mem[8'(bif.mem_addr[7:0] + 8'(i))] <= bif.mem_wd[8*i +: 8];
    end
  end

  // ---------------- monitor ----------------
  int          n_rd = 0, n_wr = 0, n_resp = 0, n_acc = 0;
  logic [31:0] rd_addr_q[$];
  logic [2:0]  rd_op_q[$];

  always @(negedge clk) begin
    if (bif.mem_we) n_wr++;
    else if (bif.mem_addrsrc && bif.mem_op != 3'b000) begin
      n_rd++;
      rd_addr_q.push_back(bif.mem_addr);
      rd_op_q.push_back(bif.mem_op);
    end
    if (bif.resp_valid) n_resp++;
    if (bif.req_valid && bif.req_ready) n_acc++;
  end

  // ---------------- reference model ----------------
  function automatic int op_size(logic [2:0] op);
    if (op == 3'b001 || op == 3'b100) return 1;
    if (op == 3'b010 || op == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(logic [2:0] op, logic [31:0] a);
    int sz;
    sz = op_size(op);
    return (sz > 1) && ((a[1:0] + sz) > 4 || (sz == 4 && a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < op_size(op); i++) v[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
    if (op == 3'b001) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'b010) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < op_size(op); i++) ref_mem[8'(a[7:0] + 8'(i))] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] mem_word(int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // ---------------- checking / driving ----------------
  int n_total = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata);
    int          rd_b, wr_b, lat, exp_lat, exp_rd, exp_wr;
    logic        mis;
    logic [31:0] exp;
    mis     = is_mis(op, a);
    exp_lat = !mis ? 2 : (we ? 5 : 3);
    exp_rd  = !mis ? (we ? 0 : 1) : 2;
    exp_wr  = !mis ? (we ? 1 : 0) : (we ? 2 : 0);
    rd_b = n_rd;
    wr_b = n_wr;
    chk({tag, " ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_op    = op;
    bif.req_addr  = a;
    bif.req_wdata = d;
    step();
    bif.req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bif.resp_valid) begin
        lat = k;
        break;
      end
    end
    if (we) begin
      exp = 32'd0;
      ref_store(op, a, d);
    end else begin
      exp = ref_load(op, a);
    end
    rdata = bif.resp_rdata;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, bif.resp_rdata, exp);
    chk({tag, " reads"}, 32'(n_rd - rd_b), 32'(exp_rd));
    chk({tag, " writes"}, 32'(n_wr - wr_b), 32'(exp_wr));
  endtask

  initial begin
    logic [31:0] rd;
    int          resp_b, acc_b, bad, qn;

    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_op    = 3'b000;
    bif.req_addr  = 32'd0;
    bif.req_wdata = 32'd0;

    // reset state
    reset_n = 1'b0;
    step();
    chk("mem_we in reset", 32'(bif.mem_we), 32'd0);
    step();
    reset_n = 1'b1;
    chk("rst resp_valid", 32'(bif.resp_valid), 32'd0);
    chk("rst resp_rdata", bif.resp_rdata, 32'd0);
    chk("rst mem_op", 32'(bif.mem_op), 32'd0);
    chk("rst mem_addr", bif.mem_addr, 32'd0);
    chk("rst mem_wd", bif.mem_wd, 32'd0);
    chk("rst mem_addrsrc", 32'(bif.mem_addrsrc), 32'd0);
    chk("rst req_ready", 32'(bif.req_ready), 32'd1);
    chk("rst busy", 32'(bif.busy), 32'd0);

    // 1: aligned word load, response data held afterwards
    preload();
    qn = rd_addr_q.size();
    run_req("lw10", 1'b0, 3'b011, 32'h10, 32'd0, rd);
    chk("lw10 const", rd, 32'h44332211);
    chk("lw10 op", 32'(rd_op_q[qn]), 32'h3);
    step(); step(); step();
    chk("lw10 hold", bif.resp_rdata, 32'h44332211);

    // 2: misaligned word load
    qn = rd_addr_q.size();
    run_req("lw11", 1'b0, 3'b011, 32'h11, 32'd0, rd);
    chk("lw11 const", rd, 32'h55443322);
    chk("lw11 addr0", rd_addr_q[qn], 32'h10);
    chk("lw11 addr1", rd_addr_q[qn+1], 32'h14);

    // 3: half/byte loads
    run_req("lh13", 1'b0, 3'b010, 32'h13, 32'd0, rd);
    chk("lh13 const", rd, 32'h00005544);
    qn = rd_addr_q.size();
    run_req("lb17", 1'b0, 3'b001, 32'h17, 32'd0, rd);
    chk("lb17 const", rd, 32'hFFFFFF88);
    chk("lb17 op", 32'(rd_op_q[qn]), 32'h1);
    run_req("lbu17", 1'b0, 3'b100, 32'h17, 32'd0, rd);
    chk("lbu17 const", rd, 32'h00000088);

    // 4: misaligned store, read-modify-write
    run_req("sw12", 1'b1, 3'b011, 32'h12, 32'hAABBCCDD, rd);
    chk("sw12 word10", mem_word(16), 32'hCCDD2211);
    chk("sw12 word14", mem_word(20), 32'h8877AABB);

    // address wrap across the top of the space
    qn = rd_addr_q.size();
    run_req("lw_wrap", 1'b0, 3'b011, 32'hFFFFFFFD, 32'd0, rd);
    chk("wrap addr0", rd_addr_q[qn], 32'hFFFFFFFC);
    chk("wrap addr1", rd_addr_q[qn+1], 32'h00000000);

    // 5: reset during WR1 of a misaligned store
    preload();
    resp_b = n_resp;
    bif.req_valid = 1'b1;
    bif.req_we    = 1'b1;
    bif.req_op    = 3'b011;
    bif.req_addr  = 32'h12;
    bif.req_wdata = 32'hAABBCCDD;
    step();
    bif.req_valid = 1'b0;
    step(); step(); step();
    chk("abort wr1 we", 32'(bif.mem_we), 32'd1);
    chk("abort wr1 addr", bif.mem_addr, 32'h14);
    reset_n = 1'b0;
    #1;
    chk("abort mem_we", 32'(bif.mem_we), 32'd0);
    step();
    chk("abort ready", 32'(bif.req_ready), 32'd1);
    chk("abort resp_valid", 32'(bif.resp_valid), 32'd0);
    reset_n = 1'b1;
    step(); step(); step();
    chk("abort no resp", 32'(n_resp - resp_b), 32'd0);
    chk("abort word10", mem_word(16), 32'hCCDD2211);
    chk("abort word14", mem_word(20), 32'h88776655);

    // 6: request held valid during a misaligned op
    preload();
    resp_b = n_resp;
    acc_b  = n_acc;
    bif.req_valid = 1'b1;
    bif.req_we    = 1'b0;
    bif.req_op    = 3'b011;
    bif.req_addr  = 32'h11;
    step();
    bif.req_addr = 32'h10;
    for (int k = 0; k < 10 && (n_acc - acc_b) < 2; k++) step();
    bif.req_valid = 1'b0;
    chk("hold accepts", 32'(n_acc - acc_b), 32'd2);
    chk("hold resp before 2nd", 32'(n_resp - resp_b), 32'd1);
    for (int k = 0; k < 10 && (n_resp - resp_b) < 2; k++) step();
    chk("hold 2nd rdata", bif.resp_rdata, 32'h44332211);
    step(); step(); step();
    chk("hold total resp", 32'(n_resp - resp_b), 32'd2);
    chk("hold total acc", 32'(n_acc - acc_b), 32'd2);

    // randomized requests against the byte-level reference
    preload();
    for (int it = 0; it < 60; it++) begin
      logic        we;
      logic [2:0]  op;
      logic [31:0] a, d;
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      d  = $urandom;
      run_req($sformatf("rnd%0d", it), we, op, a, d, rd);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("rnd mem image", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
